smc_param_loader: RTL and testbench

- Sequential front-end for the combinational SMC core (six-transistor current/gm sort-and-sum).
- Receives the six transistor parameter triples (W, V_GS, V_DS) serially, one device per beat; mode is sampled on the first beat.
- Assembles the triples into parallel buses and presents them to the core with a valid/ready handshake.
- Holds the buses stable for the whole presentation window, so the core output is stable until the consumer accepts it.

---
 rtl/smc_param_loader_pkg.sv | 14 +
 rtl/smc_param_loader_if.sv | 37 +++
 rtl/smc_param_loader.sv | 128 ++++++++++++
 tb/tb_smc_param_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_param_loader_pkg.sv
// Shared constants and state type for the SMC front-end loader and core.
// Optional parameter checking is enabled by defining SMC_PARAM_CHECK_EN.
package smc_pkg;
  localparam int NUM_DEV = 6;
  localparam int DW      = 3;
  localparam int MW      = 2;
  localparam int CNT_W   = $clog2(NUM_DEV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_e;
endpackage

// File: rtl/smc_param_loader_if.sv
// Serial beat input and parallel frame output of the SMC parameter loader.
// Carries param_err only when SMC_PARAM_CHECK_EN is defined.
interface smc_param_loader_if;
  import smc_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         W_in;
  logic [DW-1:0]         V_GS_in;
  logic [DW-1:0]         V_DS_in;
  logic [MW-1:0]         mode_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_DEV*DW-1:0] W_bus;
  logic [NUM_DEV*DW-1:0] V_GS_bus;
  logic [NUM_DEV*DW-1:0] V_DS_bus;
  logic [MW-1:0]         mode_out;
`ifdef SMC_PARAM_CHECK_EN
  logic                  param_err;
`endif

  modport slave (
    input  in_valid, W_in, V_GS_in, V_DS_in, mode_in, out_ready,
    output in_ready, out_valid, W_bus, V_GS_bus, V_DS_bus, mode_out
`ifdef SMC_PARAM_CHECK_EN
    , output param_err
`endif
  );

  modport master (
    output in_valid, W_in, V_GS_in, V_DS_in, mode_in, out_ready,
    input  in_ready, out_valid, W_bus, V_GS_bus, V_DS_bus, mode_out
`ifdef SMC_PARAM_CHECK_EN
    , input param_err
`endif
  );
endinterface

// File: rtl/smc_param_loader.sv
// Collects six (W, V_GS, V_DS) triples serially and presents them in
// parallel to the SMC core with a valid/ready handshake. Buses are frozen
// while a frame is presented. SMC_PARAM_CHECK_EN adds a sticky param_err
// flag flagging any device with W==0 or V_GS==0.
module smc_param_loader
  import smc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  smc_param_loader_if.slave bus
);

  localparam logic [1:0]       S_IDLE    = IDLE;
  localparam logic [1:0]       S_LOAD    = LOAD;
  localparam logic [1:0]       S_PRESENT = PRESENT;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_DEV - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DEV*DW-1:0] w_q, w_d;
  logic [NUM_DEV*DW-1:0] vgs_q, vgs_d;
  logic [NUM_DEV*DW-1:0] vds_q, vds_d;
  logic [MW-1:0]         mode_q, mode_d;
  logic                  beat;

  assign bus.in_ready  = (state_q != S_PRESENT);
  assign bus.out_valid = (state_q == S_PRESENT);
  assign bus.W_bus     = w_q;
  assign bus.V_GS_bus  = vgs_q;
  assign bus.V_DS_bus  = vds_q;
  assign bus.mode_out  = mode_q;

  assign beat = bus.in_valid && (state_q != S_PRESENT);

  // Next-state: store the beat into slot cnt, advance the frame counter and FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    vgs_d   = vgs_q;
    vds_d   = vds_q;
    mode_d  = mode_q;
    if (beat) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          w_d[DW*i +: DW]   = bus.W_in;
          vgs_d[DW*i +: DW] = bus.V_GS_in;
          vds_d[DW*i +: DW] = bus.V_DS_in;
        end
      end
      if (cnt_q == '0) begin
        mode_d = bus.mode_in;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          cnt_d   = CNT_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_PRESENT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and slot registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      vgs_q   <= '0;
      vds_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      vgs_q   <= vgs_d;
      vds_q   <= vds_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SMC_PARAM_CHECK_EN
  logic err_q, err_d;
  logic bad_dev;

  assign bad_dev       = (bus.W_in == '0) || (bus.V_GS_in == '0);
  assign bus.param_err = err_q;

  // Sticky error flag, restarted on the first beat of each frame
  always_comb begin
    err_d = err_q;
    if (beat) begin
      err_d = (cnt_q == '0) ? bad_dev : (err_q | bad_dev);
    end
  end

  // Error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_smc_param_loader.sv
// Self-checking bench for smc_param_loader: directed scenarios plus
// randomized frames compared against a per-frame array model.
// Exercises param_err when SMC_PARAM_CHECK_EN is defined.
module tb_smc_param_loader;
  import smc_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [DW-1:0] mW [NUM_DEV];
  logic [DW-1:0] mG [NUM_DEV];
  logic [DW-1:0] mD [NUM_DEV];
  logic [MW-1:0] mMode;

  smc_param_loader_if bus ();

  smc_param_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_DEV*DW-1:0] pack(input logic [DW-1:0] a [NUM_DEV]);
    logic [NUM_DEV*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DEV; i++) r[DW*i +: DW] = a[i];
    return r;
  endfunction

  function automatic logic exp_err();
    for (int i = 0; i < NUM_DEV; i++)
      if (mW[i] == 0 || mG[i] == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < NUM_DEV; i++) begin
      mW[i] = DW'($urandom_range(0, 7));
      mG[i] = DW'($urandom_range(0, 7));
      mD[i] = DW'($urandom_range(0, 7));
    end
    mMode = MW'($urandom_range(0, 3));
  endtask

  task automatic do_beat(input logic [DW-1:0] w, input logic [DW-1:0] g,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.in_valid = 1'b1;
    bus.W_in     = w;
    bus.V_GS_in  = g;
    bus.V_DS_in  = d;
    bus.mode_in  = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.W_in    = DW'($urandom);
      bus.V_GS_in = DW'($urandom);
      bus.V_DS_in = DW'($urandom);
      bus.mode_in = MW'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the model frame; mode_in carries garbage on beats 1..5
  task automatic drive_frame(input int maxGap);
    for (int i = 0; i < NUM_DEV; i++) begin
      do_beat(mW[i], mG[i], mD[i], (i == 0) ? mMode : MW'($urandom));
      if (i < NUM_DEV - 1 && maxGap > 0) idle_cycles($urandom_range(0, maxGap));
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Park a frame in PRESENT, then reset asynchronously between edges
    rand_frame();
    mW[0] = 3'd5;
    bus.out_ready = 1'b0;
    drive_frame(0);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_hs in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.W_bus !== '0 || bus.V_GS_bus !== '0 || bus.V_DS_bus !== '0 || bus.mode_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_bus W=%o G=%o D=%o mode=%0d want all 0",
               bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NUM_DEV; i++) begin
      mW[i] = DW'(i + 1);
      mG[i] = DW'(7 - i);
      mD[i] = DW'(i);
    end
    mMode = 2'b11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_DEV - 1; i++) do_beat(mW[i], mG[i], mD[i], (i == 0) ? mMode : 2'b00);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_early out_valid=%b want 0", bus.out_valid);
    end
    do_beat(mW[5], mG[5], mD[5], 2'b01);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_latency out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.W_bus !== 18'o654321 || bus.V_GS_bus !== 18'o234567 ||
        bus.V_DS_bus !== 18'o543210 || bus.mode_out !== 2'd3) begin
      fails++;
      $display("[TB] FAIL b2b_bus W=%o G=%o D=%o mode=%0d want 654321/234567/543210/3",
               bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_idle out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    rand_frame();
    bus.out_ready = 1'b1;
    do_beat(mW[0], mG[0], mD[0], mMode);
    do_beat(mW[1], mG[1], mD[1], MW'($urandom));
    idle_cycles(3);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL gap_hold out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    for (int i = 2; i < NUM_DEV; i++) do_beat(mW[i], mG[i], mD[i], MW'($urandom));
    tests++;
    if (bus.out_valid !== 1'b1 || bus.W_bus !== pack(mW) || bus.V_GS_bus !== pack(mG) ||
        bus.V_DS_bus !== pack(mD) || bus.mode_out !== mMode) begin
      fails++;
      $display("[TB] FAIL gap_frame ov=%b W=%o G=%o D=%o m=%0d want 1 %o %o %o %0d",
               bus.out_valid, bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out,
               pack(mW), pack(mG), pack(mD), mMode);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NUM_DEV*DW-1:0] sw, sg, sd;
    logic [MW-1:0]         sm;
    rand_frame();
    bus.out_ready = 1'b0;
    drive_frame(1);
    sw = pack(mW);
    sg = pack(mG);
    sd = pack(mD);
    sm = mMode;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.W_in     = DW'($urandom);
      bus.V_GS_in  = DW'($urandom);
      bus.V_DS_in  = DW'($urandom);
      bus.mode_in  = MW'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.W_bus !== sw ||
          bus.V_GS_bus !== sg || bus.V_DS_bus !== sd || bus.mode_out !== sm) begin
        fails++;
        $display("[TB] FAIL bp_frozen cyc=%0d ov=%b ir=%b W=%o G=%o D=%o m=%0d want 1 0 %o %o %o %0d",
                 k, bus.out_valid, bus.in_ready, bus.W_bus, bus.V_GS_bus, bus.V_DS_bus,
                 bus.mode_out, sw, sg, sd, sm);
      end
    end
    // Release coincides with a valid input beat, which must not be taken
    bus.out_ready = 1'b1;
    bus.W_in      = ~sw[2:0];
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.W_bus !== sw ||
        bus.V_GS_bus !== sg || bus.V_DS_bus !== sd) begin
      fails++;
      $display("[TB] FAIL bp_release ov=%b ir=%b W=%o want 0 1 %o", bus.out_valid, bus.in_ready, bus.W_bus, sw);
    end
    // Next frame starts immediately in the following cycle
    rand_frame();
    drive_frame(0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.W_bus !== pack(mW) || bus.V_GS_bus !== pack(mG) ||
        bus.V_DS_bus !== pack(mD) || bus.mode_out !== mMode) begin
      fails++;
      $display("[TB] FAIL bp_next ov=%b W=%o G=%o D=%o m=%0d want 1 %o %o %o %0d",
               bus.out_valid, bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out,
               pack(mW), pack(mG), pack(mD), mMode);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mode_sampling();
    rand_frame();
    mMode = 2'b01;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) do_beat(mW[i], mG[i], mD[i], (i == 0) ? mMode : MW'(2 + (i % 2)));
    tests++;
    if (bus.mode_out !== 2'b01) begin
      fails++;
      $display("[TB] FAIL mode_sample got=%0d want 1", bus.mode_out);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    rand_frame();
    for (int i = 0; i < 4; i++) do_beat(3'd7, 3'd7, 3'd7, 2'b10);
    pulse_reset();
    tests++;
    if (bus.W_bus !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mode_out !== '0) begin
      fails++;
      $display("[TB] FAIL rml_cleared W=%o ov=%b ir=%b m=%0d want 0 0 1 0",
               bus.W_bus, bus.out_valid, bus.in_ready, bus.mode_out);
    end
    drive_frame(0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.W_bus !== pack(mW) || bus.V_GS_bus !== pack(mG) ||
        bus.V_DS_bus !== pack(mD) || bus.mode_out !== mMode) begin
      fails++;
      $display("[TB] FAIL rml_fresh ov=%b W=%o G=%o D=%o m=%0d want 1 %o %o %o %0d",
               bus.out_valid, bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out,
               pack(mW), pack(mG), pack(mD), mMode);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

`ifdef SMC_PARAM_CHECK_EN
  task automatic test_param_check();
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        mW[i] = DW'($urandom_range(1, 7));
        mG[i] = DW'($urandom_range(1, 7));
        mD[i] = DW'($urandom_range(0, 7));
      end
      mMode = MW'($urandom);
      if (pass == 0) mG[3] = 3'd0;
      if (pass == 2) mW[5] = 3'd0;
      drive_frame(1);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.param_err !== exp_err()) begin
        fails++;
        $display("[TB] FAIL param_err pass=%0d ov=%b err=%b want 1 %b", pass, bus.out_valid, bus.param_err, exp_err());
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      rand_frame();
      bus.out_ready = 1'b0;
      drive_frame(2);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.W_bus !== pack(mW) || bus.V_GS_bus !== pack(mG) ||
          bus.V_DS_bus !== pack(mD) || bus.mode_out !== mMode) begin
        fails++;
        $display("[TB] FAIL rand_frame f=%0d ov=%b W=%o G=%o D=%o m=%0d want 1 %o %o %o %0d",
                 f, bus.out_valid, bus.W_bus, bus.V_GS_bus, bus.V_DS_bus, bus.mode_out,
                 pack(mW), pack(mG), pack(mD), mMode);
      end
`ifdef SMC_PARAM_CHECK_EN
      tests++;
      if (bus.param_err !== exp_err()) begin
        fails++;
        $display("[TB] FAIL rand_err f=%0d err=%b want %b", f, bus.param_err, exp_err());
      end
`endif
      idle_cycles($urandom_range(0, 3));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL rand_release f=%0d ov=%b ir=%b want 0 1", f, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  // Main sequence
  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.W_in      = '0;
    bus.V_GS_in   = '0;
    bus.V_DS_in   = '0;
    bus.mode_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_backpressure();
    test_mode_sampling();
    test_reset_mid_load();
`ifdef SMC_PARAM_CHECK_EN
    test_param_check();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
